// File: rtl/jam_gen_pkg.sv
// Shared definitions for the jam_gen exhaustive assignment search.
//   jam_state_e : controller state encoding (also exported on the State debug port)
//   jw_of       : index width for N workers/jobs (at least 1 bit)
//   mcw_of      : width of a summed cost for N workers and CW-bit costs
package jam_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } jam_state_e;

   function automatic int jw_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int mcw_of(input int n, input int cw);
      return cw + jw_of(n);
   endfunction

endpackage

// File: rtl/jam_next_perm.sv
// Combinational next-lexicographic-permutation generator.
//   Job     : current permutation, slice k = job of worker k
//   NextJob : lexicographic successor of Job (equals Job when Last)
//   Last    : Job is in descending order, no successor exists
module jam_next_perm
   import jam_gen_pkg::*;
#(
   parameter int N  = 8,
   localparam int JW = jw_of(N)
) (
   input  logic [N*JW-1:0] Job,
   output logic [N*JW-1:0] NextJob,
   output logic            Last
);

   logic [JW-1:0] a [N];
   logic [JW-1:0] s [N];
   logic [JW-1:0] b [N];
   logic [JW-1:0] piv;
   logic [JW-1:0] sw;
   logic [JW-1:0] pv;
   logic          has_piv;

   always_comb begin
      for (int k = 0; k < N; k++) a[k] = Job[k*JW +: JW];

      // Pivot: rightmost ascent. Ascending scan lets the last hit win.
      has_piv = 1'b0;
      piv     = '0;
      for (int i = 0; i < N-1; i++) begin
         if (a[i] < a[i+1]) begin
            has_piv = 1'b1;
            piv     = JW'(i);
         end
      end
      pv = a[piv];

      // The suffix after the pivot is descending, so the rightmost element
      // larger than the pivot value is the smallest such element.
      sw = piv;
      for (int j = 0; j < N; j++) begin
         if ((JW'(j) > piv) && (a[j] > pv)) sw = JW'(j);
      end

      s = a;
      if (has_piv) begin
         s[piv] = a[sw];
         s[sw]  = pv;
      end

      // Reverse the suffix: position k takes position m where k+m = N+piv.
      b = s;
      for (int k = 0; k < N; k++) begin
         for (int m = 0; m < N; m++) begin
            if (has_piv && (JW'(k) > piv) && (JW'(m) > piv) &&
                ((k + m) == (N + int'(piv))))
               b[k] = s[m];
         end
      end

      NextJob = '0;
      for (int k = 0; k < N; k++) NextJob[k*JW +: JW] = b[k];
      Last = !has_piv;
   end

endmodule

// File: rtl/jam_gen.sv
// Exhaustive minimum-cost assignment search over all N! permutations.
// Each permutation is scored in N CALC cycles (one table lookup per worker)
// followed by one CHECK cycle that updates the results and steps to the
// next lexicographic permutation.
//   CLK, RST   : clock, synchronous active-high reset
//   Start      : begin a search (honoured in IDLE or DONE only)
//   W, J       : worker/job index driven to the external cost table
//   Cost       : combinational table response for (W,J)
//   MinCost    : lowest total cost found
//   MatchCount : number of permutations reaching MinCost
//   BestJob    : first permutation reaching MinCost, slice k = job of worker k
//   Busy       : search running (CALC/CHECK)
//   Valid      : results final (DONE)
//   State      : controller state, for debug/checkers
// Start is a level sampled on the clock; no handshake beyond that. Results
// are meaningful only while Valid is high and are held until the next Start.
module jam_gen
   import jam_gen_pkg::*;
#(
   parameter int N   = 8,
   parameter int CW  = 7,
   localparam int JW  = jw_of(N),
   localparam int MCW = mcw_of(N, CW)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Start,
   output logic [JW-1:0]    W,
   output logic [JW-1:0]    J,
   input  logic [CW-1:0]    Cost,
   output logic [MCW-1:0]   MinCost,
   output logic [15:0]      MatchCount,
   output logic [N*JW-1:0]  BestJob,
   output logic             Busy,
   output logic             Valid,
   output jam_state_e       State
);

   function automatic logic [N*JW-1:0] identity_perm();
      logic [N*JW-1:0] r;
      r = '0;
      for (int k = 0; k < N; k++) r[k*JW +: JW] = JW'(k);
      return r;
   endfunction

   jam_state_e       state, state_n;
   logic [JW-1:0]    w_q;
   logic [MCW-1:0]   cur_cost;
   logic [MCW-1:0]   min_cost;
   logic [15:0]      match_cnt;
   logic [N*JW-1:0]  job;
   logic [N*JW-1:0]  best_job;
   logic [N*JW-1:0]  next_job;
   logic             last_perm;
   logic [JW-1:0]    j_sel;
   logic             start_acc;

   jam_next_perm #(.N(N)) u_next_perm (
      .Job     (job),
      .NextJob (next_job),
      .Last    (last_perm)
   );

   assign start_acc = Start && ((state == ST_IDLE) || (state == ST_DONE));

   always_ff @(posedge CLK) begin
      if (RST) state <= ST_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:  if (Start) state_n = ST_CALC;
         ST_CALC:  if (w_q == JW'(N-1)) state_n = ST_CHECK;
         ST_CHECK: state_n = last_perm ? ST_DONE : ST_CALC;
         ST_DONE:  if (Start) state_n = ST_CALC;
         default:  state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         w_q       <= '0;
         cur_cost  <= '0;
         min_cost  <= '1;
         match_cnt <= '0;
         job       <= identity_perm();
         best_job  <= identity_perm();
      end else if (start_acc) begin
         w_q       <= '0;
         cur_cost  <= '0;
         min_cost  <= '1;
         match_cnt <= '0;
         job       <= identity_perm();
         best_job  <= identity_perm();
      end else begin
         case (state)
            ST_CALC: begin
               cur_cost <= cur_cost + MCW'(Cost);
               w_q      <= (w_q == JW'(N-1)) ? '0 : w_q + 1'b1;
            end
            ST_CHECK: begin
               if (cur_cost < min_cost) begin
                  min_cost  <= cur_cost;
                  match_cnt <= 16'd1;
                  best_job  <= job;
               end else if (cur_cost == min_cost) begin
                  match_cnt <= match_cnt + 16'd1;
               end
               cur_cost <= '0;
               w_q      <= '0;
               // The last permutation has no successor; keep it as is.
               if (!last_perm) job <= next_job;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      j_sel = '0;
      for (int k = 0; k < N; k++) begin
         if (w_q == JW'(k)) j_sel = job[k*JW +: JW];
      end
   end

   assign W          = w_q;
   assign J          = j_sel;
   assign MinCost    = min_cost;
   assign MatchCount = match_cnt;
   assign BestJob    = best_job;
   assign Busy       = (state == ST_CALC) || (state == ST_CHECK);
   assign Valid      = (state == ST_DONE);
   assign State      = state;

endmodule

// File: tb/tb_jam_gen.sv
// Bench for jam_gen: three instances (N=2, 4, 6) sharing clock and reset,
// driven one at a time by directed steps and random cost matrices.
module tb_jam_gen;
   import jam_gen_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic start2, start4, start6;

   logic [0:0]  w2, j2;
   logic [6:0]  cost2;
   logic [7:0]  min2;
   logic [15:0] cnt2;
   logic [1:0]  best2;
   logic        busy2, valid2;
   jam_state_e  st2;

   logic [1:0]  w4, j4;
   logic [6:0]  cost4;
   logic [8:0]  min4;
   logic [15:0] cnt4;
   logic [7:0]  best4;
   logic        busy4, valid4;
   jam_state_e  st4;

   logic [2:0]  w6, j6;
   logic [6:0]  cost6;
   logic [9:0]  min6;
   logic [15:0] cnt6;
   logic [17:0] best6;
   logic        busy6, valid6;
   jam_state_e  st6;

   int gm [8][8];
   int n_checks = 0;
   int n_fail   = 0;
   int g_min, g_cnt;
   logic [63:0] g_best;

   always #5 clk = ~clk;

   assign cost2 = 7'(gm[int'(w2)][int'(j2)]);
   assign cost4 = 7'(gm[int'(w4)][int'(j4)]);
   assign cost6 = 7'(gm[int'(w6)][int'(j6)]);

   jam_gen #(.N(2), .CW(7)) u2 (
      .CLK(clk), .RST(rst), .Start(start2), .W(w2), .J(j2), .Cost(cost2),
      .MinCost(min2), .MatchCount(cnt2), .BestJob(best2),
      .Busy(busy2), .Valid(valid2), .State(st2));

   jam_gen #(.N(4), .CW(7)) u4 (
      .CLK(clk), .RST(rst), .Start(start4), .W(w4), .J(j4), .Cost(cost4),
      .MinCost(min4), .MatchCount(cnt4), .BestJob(best4),
      .Busy(busy4), .Valid(valid4), .State(st4));

   jam_gen #(.N(6), .CW(7)) u6 (
      .CLK(clk), .RST(rst), .Start(start6), .W(w6), .J(j6), .Cost(cost6),
      .MinCost(min6), .MatchCount(cnt6), .BestJob(best6),
      .Busy(busy6), .Valid(valid6), .State(st6));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int jw_for(input int n);
      return (n == 2) ? 1 : (n == 4) ? 2 : 3;
   endfunction

   function automatic int fact(input int n);
      int f = 1;
      for (int i = 2; i <= n; i++) f *= i;
      return f;
   endfunction

   function automatic logic [63:0] ident_packed(input int n);
      logic [63:0] r = '0;
      for (int k = 0; k < n; k++) r |= 64'(k) << (k * jw_for(n));
      return r;
   endfunction

   task automatic set_start(input int n, input logic v);
      case (n)
         2:       start2 = v;
         4:       start4 = v;
         default: start6 = v;
      endcase
   endtask

   function automatic logic [63:0] get_valid(input int n);
      case (n) 2: return 64'(valid2); 4: return 64'(valid4); default: return 64'(valid6); endcase
   endfunction
   function automatic logic [63:0] get_busy(input int n);
      case (n) 2: return 64'(busy2); 4: return 64'(busy4); default: return 64'(busy6); endcase
   endfunction
   function automatic logic [63:0] get_min(input int n);
      case (n) 2: return 64'(min2); 4: return 64'(min4); default: return 64'(min6); endcase
   endfunction
   function automatic logic [63:0] get_cnt(input int n);
      case (n) 2: return 64'(cnt2); 4: return 64'(cnt4); default: return 64'(cnt6); endcase
   endfunction
   function automatic logic [63:0] get_best(input int n);
      case (n) 2: return 64'(best2); 4: return 64'(best4); default: return 64'(best6); endcase
   endfunction
   function automatic logic [63:0] get_w(input int n);
      case (n) 2: return 64'(w2); 4: return 64'(w4); default: return 64'(w6); endcase
   endfunction
   function automatic logic [63:0] get_state(input int n);
      case (n) 2: return 64'(st2); 4: return 64'(st4); default: return 64'(st6); endcase
   endfunction

   // Reference: walk every n-digit base-n number in ascending order (worker 0
   // most significant), keep only those with distinct digits -- this visits
   // permutations in lexicographic order -- and score each directly.
   task automatic compute_golden(input int n);
      int d [8];
      int total, tmp, used, sum;
      bit ok;
      total  = 1;
      for (int i = 0; i < n; i++) total *= n;
      g_min  = 1 << 30;
      g_cnt  = 0;
      g_best = '0;
      for (int code = 0; code < total; code++) begin
         tmp = code;
         for (int w = n - 1; w >= 0; w--) begin
            d[w] = tmp % n;
            tmp  = tmp / n;
         end
         used = 0; ok = 1'b1; sum = 0;
         for (int w = 0; w < n; w++) begin
            if (used[d[w]]) ok = 1'b0;
            used |= (1 << d[w]);
            sum  += gm[w][d[w]];
         end
         if (ok) begin
            if (sum < g_min) begin
               g_min  = sum;
               g_cnt  = 1;
               g_best = '0;
               for (int k = 0; k < n; k++) g_best |= 64'(d[k]) << (k * jw_for(n));
            end else if (sum == g_min) begin
               g_cnt++;
            end
         end
      end
   endtask

   task automatic check_reset(input int n);
      string p;
      p = $sformatf("N%0d reset", n);
      check({p, " state"}, get_state(n), 64'(ST_IDLE));
      check({p, " busy"},  get_busy(n),  64'd0);
      check({p, " valid"}, get_valid(n), 64'd0);
      check({p, " w"},     get_w(n),     64'd0);
      check({p, " min"},   get_min(n),   (64'd1 << (7 + jw_for(n))) - 64'd1);
      check({p, " cnt"},   get_cnt(n),   64'd0);
      check({p, " best"},  get_best(n),  ident_packed(n));
   endtask

   // Start a search on instance n and wait for Valid, then compare with
   // g_min/g_cnt/g_best. trace checks the W/J sequence of the first two
   // permutations (N=4 only); inject pulses Start while busy.
   task automatic run_dut(input int n, input string tag, input bit trace, input bit inject);
      int exp_lat, cyc;
      int pm [2][4];
      pm = '{'{0, 1, 2, 3}, '{0, 1, 3, 2}};
      exp_lat = fact(n) * (n + 1);
      @(negedge clk);
      set_start(n, 1'b1);
      @(posedge clk);
      #1;
      set_start(n, 1'b0);
      check({tag, " busy after start"}, get_busy(n), 64'd1);
      check({tag, " valid after start"}, get_valid(n), 64'd0);
      cyc = 0;
      while (get_valid(n) !== 64'd1 && cyc < exp_lat + 50) begin
         if (trace && cyc < 10) begin
            if (cyc % 5 == 4) begin
               check($sformatf("%s W check cyc%0d", tag, cyc), 64'(w4), 64'd0);
            end else begin
               check($sformatf("%s W cyc%0d", tag, cyc), 64'(w4), 64'(cyc % 5));
               check($sformatf("%s J cyc%0d", tag, cyc), 64'(j4), 64'(pm[cyc / 5][cyc % 5]));
            end
         end
         @(posedge clk);
         #1;
         cyc++;
         set_start(n, inject && (cyc == 37 || cyc == 1500 || cyc == 3001));
      end
      set_start(n, 1'b0);
      check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
      check({tag, " min"},   get_min(n),  64'(g_min));
      check({tag, " cnt"},   get_cnt(n),  64'(g_cnt));
      check({tag, " best"},  get_best(n), g_best);
      check({tag, " busy done"}, get_busy(n), 64'd0);
      check({tag, " w done"},    get_w(n),    64'd0);
      repeat (3) @(posedge clk);
      #1;
      check({tag, " valid held"}, get_valid(n), 64'd1);
      check({tag, " cnt held"},   get_cnt(n),   64'(g_cnt));
   endtask

   task automatic fill_random(input int n, input int maxv);
      for (int w = 0; w < 8; w++)
         for (int j = 0; j < 8; j++)
            gm[w][j] = (w < n && j < n) ? int'($urandom_range(0, maxv)) : 0;
   endtask

   initial begin
      rst = 1'b1;
      start2 = 1'b0; start4 = 1'b0; start6 = 1'b0;
      for (int w = 0; w < 8; w++) for (int j = 0; j < 8; j++) gm[w][j] = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset(2);
      check_reset(4);
      check_reset(6);

      // No auto-start after reset.
      repeat (10) @(posedge clk);
      #1;
      check("N4 idle no autostart busy", get_busy(4), 64'd0);
      check("N6 idle no autostart state", get_state(6), 64'(ST_IDLE));

      // N=2, Cost = W+J: both permutations cost 2.
      for (int w = 0; w < 2; w++) for (int j = 0; j < 2; j++) gm[w][j] = w + j;
      g_min = 2; g_cnt = 2; g_best = 64'h2;
      run_dut(2, "N2 w+j", 1'b0, 1'b0);

      // N=4 diagonal zero: identity is the unique optimum.
      for (int w = 0; w < 4; w++) for (int j = 0; j < 4; j++) gm[w][j] = (w == j) ? 0 : 10;
      g_min = 0; g_cnt = 1; g_best = 64'hE4;
      run_dut(4, "N4 diag", 1'b1, 1'b0);

      // Restart from DONE with anti-diagonal: optimum is the last permutation.
      for (int w = 0; w < 4; w++) for (int j = 0; j < 4; j++) gm[w][j] = (j == 3 - w) ? 1 : 9;
      g_min = 4; g_cnt = 1; g_best = 64'h1B;
      run_dut(4, "N4 antidiag", 1'b0, 1'b0);

      // Random N=4 matrices, narrow ranges produce ties.
      for (int r = 0; r < 6; r++) begin
         fill_random(4, (r % 2 == 0) ? 127 : 2);
         compute_golden(4);
         run_dut(4, $sformatf("N4 rand%0d", r), 1'b0, 1'b0);
      end

      // Random N=6 with Start pulses while busy.
      fill_random(6, 127);
      compute_golden(6);
      run_dut(6, "N6 rand inject", 1'b0, 1'b1);

      // Mid-run reset of N=6 at cycle 1000 after Start.
      fill_random(6, 127);
      @(negedge clk);
      start6 = 1'b1;
      @(posedge clk);
      #1;
      start6 = 1'b0;
      repeat (999) @(posedge clk);
      #1;
      check("N6 busy before reset", get_busy(6), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset(6);
      repeat (20) @(posedge clk);
      #1;
      check("N6 no autostart after reset", get_state(6), 64'(ST_IDLE));

      // Restart after reset with a tie-heavy matrix.
      fill_random(6, 3);
      compute_golden(6);
      run_dut(6, "N6 rand restart", 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/jam_gen.md
JAM_GEN -- requirements
Module: jam_gen

Interface
REQ-001 Parameter N, default 8, number of workers = number of jobs; legal range 2..8.
REQ-002 Parameter CW, default 7, Cost input width.
REQ-003 Derived constants: JW = $clog2(N) (min 1) is the index width; MCW = CW + JW is the cost-sum width.
REQ-004 CLK  input  1  sole clock, rising-edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 Start  input  1  begin an enumeration; sampled in IDLE or DONE only.
REQ-007 W  output  JW  worker index presented to the external cost table.
REQ-008 J  output  JW  job index presented to the external cost table.
REQ-009 Cost  input  CW  cost of (W,J), combinational from the table, valid in the same cycle.
REQ-010 MinCost  output  MCW  minimum total cost found.
REQ-011 MatchCount  output  16  number of permutations that achieve MinCost.
REQ-012 BestJob  output  N*JW  first permutation (lexicographic order) that reaches MinCost; slice k = job of worker k.
REQ-013 Busy  output  1  high in CALC and CHECK.
REQ-014 Valid  output  1  high in DONE.

Function
REQ-015 The FSM states shall be IDLE, CALC, CHECK and DONE.
REQ-016 Transitions: IDLE-(Start)->CALC; CALC-(W==N-1)->CHECK; CHECK-(current perm is last)->DONE, otherwise ->CALC; DONE-(Start)->CALC.
REQ-017 On Start accept: Job = identity (0..N-1); CurCost, W = 0; MinCost = all ones; MatchCount = 0; BestJob = identity.
REQ-018 CALC: W increments 0..N-1, one step per cycle; J = Job[W] combinationally; CurCost += zero-extended Cost at each edge.
REQ-019 CHECK, CurCost < MinCost: MinCost = CurCost; MatchCount = 1; BestJob = Job.
REQ-020 CHECK, CurCost == MinCost: MatchCount += 1; BestJob unchanged.
REQ-021 CHECK, CurCost > MinCost: no update.
REQ-022 CHECK also clears CurCost and W, and loads Job with its next lexicographic permutation: pivot = rightmost i with Job[i] < Job[i+1]; swap with the smallest suffix element greater than Job[i]; reverse the suffix after i.
REQ-023 "Last" = no ascent exists (descending order); this permutation is still scored before DONE.
REQ-024 Each permutation takes exactly N+1 cycles; Start accept to Valid = N!*(N+1) cycles (N=8: 362880).
REQ-025 Outside CALC, W = 0.
REQ-026 MinCost, MatchCount and BestJob are intermediate while Busy; they are final and held while Valid.
REQ-027 Start in CALC/CHECK is ignored. Start in DONE restarts and clears all results (REQ-017).
REQ-028 Arithmetic never overflows: N*(2^CW-1) < 2^MCW, and N! <= 40320 < 2^16.

Reset
REQ-029 RST (any state, including mid-run) forces: state IDLE; W = 0; CurCost = 0; MinCost = all ones; MatchCount = 0; Job = BestJob = identity; Busy = Valid = 0.
REQ-030 After reset there is no auto-start; the block waits for Start.

Structure
REQ-031 Package jam_gen_pkg shall hold the state encoding and the JW/MCW width helper functions.
REQ-032 Sub-module jam_next_perm (combinational): input Job vector; outputs next permutation and last flag; parametrised by N.

Verification
REQ-033 N=8, constant Cost=5, Start pulse -> Valid at cycle 362880; MinCost=40; MatchCount=40320; BestJob=0,1,..,7.
REQ-034 N=4, Cost=0 if J==W else 10 -> MinCost=0; MatchCount=1; BestJob=0,1,2,3.
REQ-035 N=4, Cost=1 if J==3-W else 9 -> MinCost=4; MatchCount=1; BestJob=3,2,1,0 (last perm scored).
REQ-036 N=2, Cost=W+J -> Valid 6 cycles after Start; MinCost=2; MatchCount=2; BestJob=0,1.
REQ-037 N=8, random 7-bit matrix vs software golden; Start pulses mid-run are ignored; RST at cycle 1000 gives reset values; a re-Start produces golden results.
REQ-038 After DONE, Start with a new matrix (REQ-034 then REQ-035) -> results fully replaced, no carry-over of MatchCount.
